// File: rtl/reg_file_pkg.sv
// Shared types and default sizing for the parametrised register file.
package reg_file_pkg;

    // Bulk-clear sequencer state encoding.
    typedef enum logic {
        IDLE     = 1'b0,
        CLEARING = 1'b1
    } clr_state_e;

    // Default geometry of the register file.
    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 8;

endpackage

// File: rtl/reg_file_clear_seq.sv
// Bulk-clear sequencer: walks the register file one entry per cycle,
// reports its state (BUSY is derived from it by the top) and flags
// writes that arrive while a clear is running.
//
// Handshake: a CLEAR sampled in IDLE starts a sequence of exactly DEPTH
// cycles in CLEARING. While CLEARING, external writes are refused and
// flagged one cycle later on wr_drop_o. Further CLEAR requests are ignored
// until the sequence returns to IDLE.
module reg_file_clear_seq
    import reg_file_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clear_i,
    input  logic          write_i,
    output clr_state_e    state_o,
    output logic          wr_drop_o,
    output logic          clr_en_o,
    output logic [AW-1:0] clr_addr_o
);

    localparam logic [AW-1:0] CNT_LAST = AW'(DEPTH - 1);

    clr_state_e    state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          wr_drop_q, wr_drop_d;

    // State, counter and drop flag registers; reset aborts any clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            wr_drop_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_drop_q <= wr_drop_d;
        end
    end

    // Next-state logic: start on CLEAR, count to the last entry, then stop.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_drop_d = write_i && (state_q == CLEARING);
        case (state_q)
            IDLE: begin
                if (clear_i) begin
                    state_d = CLEARING;
                    cnt_d   = '0;
                end
            end
            CLEARING: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign state_o    = state_q;
    assign wr_drop_o  = wr_drop_q;
    assign clr_en_o   = (state_q == CLEARING);
    assign clr_addr_o = cnt_q;

endmodule

// File: rtl/reg_file_param.sv
// DEPTH x WIDTH register file: two combinational read ports, one clocked
// write port, optional hardwired-zero r0, optional write-to-read bypass and
// a sequenced bulk clear. Reads and writes are modelled with zero delay.
module reg_file_param
    import reg_file_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AW       = $clog2(DEPTH),
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 0
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic [WIDTH-1:0] IN,
    input  logic [AW-1:0]    INADDRESS,
    input  logic             WRITE,
    input  logic [AW-1:0]    OUT1ADDRESS,
    input  logic [AW-1:0]    OUT2ADDRESS,
    output logic [WIDTH-1:0] OUT1,
    output logic [WIDTH-1:0] OUT2,
    input  logic             CLEAR,
    output logic             BUSY,
    output logic             WR_DROP
);

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];

    clr_state_e    clr_state;
    logic          clr_en;
    logic [AW-1:0] clr_addr;
    logic          wr_en;

    reg_file_clear_seq #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_clear_seq (
        .clk_i      (CLK),
        .rst_ni     (RESET_N),
        .clear_i    (CLEAR),
        .write_i    (WRITE),
        .state_o    (clr_state),
        .wr_drop_o  (WR_DROP),
        .clr_en_o   (clr_en),
        .clr_addr_o (clr_addr)
    );

    assign BUSY = (clr_state == CLEARING);

    // A write lands only when idle and, with a hardwired r0, not aimed at r0.
    assign wr_en = WRITE && !BUSY && !((ZERO_REG != 0) && (INADDRESS == '0));

    // Write mux: the clear engine overrides the external write path.
    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[INADDRESS] = IN;
        end
        if (clr_en) begin
            regs_d[clr_addr] = '0;
        end
    end

    // Storage array with asynchronous clear of every entry.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read port 1: array lookup, hardwired zero, then bypass of the live write.
    always_comb begin
        OUT1 = regs_q[OUT1ADDRESS];
        if ((ZERO_REG != 0) && (OUT1ADDRESS == '0)) begin
            OUT1 = '0;
        end
        if ((BYPASS != 0) && wr_en && (INADDRESS == OUT1ADDRESS)) begin
            OUT1 = IN;
        end
    end

    // Read port 2: same selection as port 1.
    always_comb begin
        OUT2 = regs_q[OUT2ADDRESS];
        if ((ZERO_REG != 0) && (OUT2ADDRESS == '0)) begin
            OUT2 = '0;
        end
        if ((BYPASS != 0) && wr_en && (INADDRESS == OUT2ADDRESS)) begin
            OUT2 = IN;
        end
    end

endmodule

// File: tb/tb_reg_file_param.sv
// Bench for reg_file_param: a plain instance and a ZERO_REG/BYPASS instance
// share one set of stimulus; expected read data comes from a bench model.
module tb_reg_file_param;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_d;
    logic [2:0] in_addr;
    logic       wr;
    logic [2:0] o1a;
    logic [2:0] o2a;
    logic       clr;

    logic [7:0] out1_a, out2_a, out1_b, out2_b;
    logic       busy_a, drop_a, busy_b, drop_b;

    logic [7:0] mdl [8];
    logic [7:0] exp_q [$];
    logic [7:0] exp;
    int         n_cmp;
    int         n_err;

    reg_file_param #(
        .WIDTH(8), .DEPTH(8), .ZERO_REG(0), .BYPASS(0)
    ) dut_a (
        .CLK(clk), .RESET_N(rst_n), .IN(in_d), .INADDRESS(in_addr),
        .WRITE(wr), .OUT1ADDRESS(o1a), .OUT2ADDRESS(o2a),
        .OUT1(out1_a), .OUT2(out2_a), .CLEAR(clr), .BUSY(busy_a),
        .WR_DROP(drop_a)
    );

    reg_file_param #(
        .WIDTH(8), .DEPTH(8), .ZERO_REG(1), .BYPASS(1)
    ) dut_b (
        .CLK(clk), .RESET_N(rst_n), .IN(in_d), .INADDRESS(in_addr),
        .WRITE(wr), .OUT1ADDRESS(o1a), .OUT2ADDRESS(o2a),
        .OUT1(out1_b), .OUT2(out2_b), .CLEAR(clr), .BUSY(busy_b),
        .WR_DROP(drop_b)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Driver: one accepted write in IDLE, reflected in the model.
    task automatic do_write(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        in_d    = d;
        in_addr = a;
        wr      = 1'b1;
        @(negedge clk);
        wr      = 1'b0;
        mdl[a]  = d;
    endtask

    task automatic model_clear_all();
        for (int i = 0; i < 8; i++) mdl[i] = 8'h00;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        o1a = 3'd3; o2a = 3'd7;
        exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        #1;
        exp = exp_q.pop_front(); n_cmp++;
        if (out1_a !== exp) begin n_err++; $display("FAIL rst_out1: got %h exp %h", out1_a, exp); end
        exp = exp_q.pop_front(); n_cmp++;
        if (out2_a !== exp) begin n_err++; $display("FAIL rst_out2: got %h exp %h", out2_a, exp); end
        n_cmp++;
        if (busy_a !== 1'b0 || drop_a !== 1'b0) begin
            n_err++; $display("FAIL rst_flags: got busy %b drop %b exp 0 0", busy_a, drop_a);
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_write(3'd3, 8'hA5);
        // Asynchronous reset in the middle of a cycle with data loaded.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        model_clear_all();
        exp_q.push_back(mdl[3]);
        #1;
        exp = exp_q.pop_front(); n_cmp++;
        if (out1_a !== exp) begin n_err++; $display("FAIL rst_async_out1: got %h exp %h", out1_a, exp); end
        n_cmp++;
        if (busy_a !== 1'b0) begin n_err++; $display("FAIL rst_async_busy: got %b exp 0", busy_a); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_write_read();
        do_write(3'd3, 8'hA5);
        do_write(3'd7, 8'h3C);
        o1a = 3'd3; o2a = 3'd7;
        exp_q.push_back(mdl[3]); exp_q.push_back(mdl[7]);
        #1;
        exp = exp_q.pop_front(); n_cmp++;
        if (out1_a !== exp) begin n_err++; $display("FAIL wr_rd_r3: got %h exp %h", out1_a, exp); end
        exp = exp_q.pop_front(); n_cmp++;
        if (out2_a !== exp) begin n_err++; $display("FAIL wr_rd_r7: got %h exp %h", out2_a, exp); end
        // Without bypass the new value is not visible before the edge.
        @(negedge clk);
        in_d = 8'h11; in_addr = 3'd6; wr = 1'b1; o1a = 3'd6;
        exp_q.push_back(mdl[6]);
        #1;
        exp = exp_q.pop_front(); n_cmp++;
        if (out1_a !== exp) begin n_err++; $display("FAIL rd_before_edge: got %h exp %h", out1_a, exp); end
        @(negedge clk);
        wr = 1'b0; mdl[6] = 8'h11;
        exp_q.push_back(mdl[6]);
        #1;
        exp = exp_q.pop_front(); n_cmp++;
        if (out1_a !== exp) begin n_err++; $display("FAIL rd_after_edge: got %h exp %h", out1_a, exp); end
    endtask

    task automatic test_zero_bypass();
        @(negedge clk);
        in_d = 8'hFF; in_addr = 3'd0; wr = 1'b1; o1a = 3'd0; o2a = 3'd0;
        exp_q.push_back(8'h00);
        #1;
        exp = exp_q.pop_front(); n_cmp++;
        if (out2_b !== exp) begin n_err++; $display("FAIL zr_no_bypass_r0: got %h exp %h", out2_b, exp); end
        @(negedge clk);
        wr = 1'b0; mdl[0] = 8'hFF;
        exp_q.push_back(8'h00); exp_q.push_back(mdl[0]);
        #1;
        exp = exp_q.pop_front(); n_cmp++;
        if (out1_b !== exp) begin n_err++; $display("FAIL zr_rd_r0: got %h exp %h", out1_b, exp); end
        exp = exp_q.pop_front(); n_cmp++;
        if (out1_a !== exp) begin n_err++; $display("FAIL plain_rd_r0: got %h exp %h", out1_a, exp); end
        @(negedge clk);
        in_d = 8'h42; in_addr = 3'd5; wr = 1'b1; o1a = 3'd5; o2a = 3'd7;
        exp_q.push_back(8'h42); exp_q.push_back(mdl[5]); exp_q.push_back(mdl[7]);
        #1;
        exp = exp_q.pop_front(); n_cmp++;
        if (out1_b !== exp) begin n_err++; $display("FAIL byp_same_cycle: got %h exp %h", out1_b, exp); end
        exp = exp_q.pop_front(); n_cmp++;
        if (out1_a !== exp) begin n_err++; $display("FAIL nobyp_same_cycle: got %h exp %h", out1_a, exp); end
        exp = exp_q.pop_front(); n_cmp++;
        if (out2_b !== exp) begin n_err++; $display("FAIL byp_other_port: got %h exp %h", out2_b, exp); end
        @(negedge clk);
        wr = 1'b0; mdl[5] = 8'h42;
        exp_q.push_back(mdl[5]);
        #1;
        exp = exp_q.pop_front(); n_cmp++;
        if (out1_b !== exp) begin n_err++; $display("FAIL byp_after_edge: got %h exp %h", out1_b, exp); end
    endtask

    task automatic test_clear();
        for (int k = 0; k < 8; k++) do_write(k[2:0], 8'(k + 1));
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        // Each sample below sees k entries already cleared.
        for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if (busy_a !== 1'b1) begin n_err++; $display("FAIL clr_busy_%0d: got %b exp 1", k, busy_a); end
            o1a = k[2:0];
            exp_q.push_back(mdl[k]);
            if (k > 0) begin
                o2a = 3'(k - 1);
                exp_q.push_back(mdl[k - 1]);
            end
            #1;
            exp = exp_q.pop_front(); n_cmp++;
            if (out1_a !== exp) begin n_err++; $display("FAIL clr_pending_%0d: got %h exp %h", k, out1_a, exp); end
            if (k > 0) begin
                exp = exp_q.pop_front(); n_cmp++;
                if (out2_a !== exp) begin n_err++; $display("FAIL clr_done_%0d: got %h exp %h", k - 1, out2_a, exp); end
            end
            @(negedge clk);
            mdl[k] = 8'h00;
        end
        n_cmp++;
        if (busy_a !== 1'b0) begin n_err++; $display("FAIL clr_busy_end: got %b exp 0", busy_a); end
        for (int i = 0; i < 8; i++) begin
            o1a = i[2:0];
            exp_q.push_back(mdl[i]);
            #1;
            exp = exp_q.pop_front(); n_cmp++;
            if (out1_a !== exp) begin n_err++; $display("FAIL clr_final_r%0d: got %h exp %h", i, out1_a, exp); end
        end
    endtask

    task automatic test_write_during_clear();
        int nbusy;
        int guard;
        do_write(3'd2, 8'h55);
        // CLEAR and WRITE together: the write lands, then gets cleared.
        @(negedge clk);
        clr = 1'b1; wr = 1'b1; in_addr = 3'd4; in_d = 8'h77;
        @(negedge clk);
        mdl[4] = 8'h77;
        nbusy = (busy_a === 1'b1) ? 1 : 0;
        o1a = 3'd4;
        exp_q.push_back(mdl[4]);
        #1;
        exp = exp_q.pop_front(); n_cmp++;
        if (out1_a !== exp) begin n_err++; $display("FAIL clr_wr_same: got %h exp %h", out1_a, exp); end
        n_cmp++;
        if (drop_a !== 1'b0) begin n_err++; $display("FAIL drop_idle_wr: got %b exp 0", drop_a); end
        // Write and second clear while busy: both refused.
        in_addr = 3'd2; in_d = 8'h99; wr = 1'b1; clr = 1'b1;
        @(negedge clk);
        wr = 1'b0; clr = 1'b0;
        if (busy_a === 1'b1) nbusy++;
        n_cmp++;
        if (drop_a !== 1'b1) begin n_err++; $display("FAIL wr_drop_pulse: got %b exp 1", drop_a); end
        n_cmp++;
        if (drop_b !== 1'b1) begin n_err++; $display("FAIL wr_drop_pulse_b: got %b exp 1", drop_b); end
        @(negedge clk);
        if (busy_a === 1'b1) nbusy++;
        n_cmp++;
        if (drop_a !== 1'b0) begin n_err++; $display("FAIL wr_drop_one_cycle: got %b exp 0", drop_a); end
        guard = 0;
        while (busy_a === 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
            if (busy_a === 1'b1) nbusy++;
        end
        n_cmp++;
        if (guard >= 20) begin n_err++; $display("FAIL busy_timeout: got busy stuck exp release within 20"); end
        n_cmp++;
        if (nbusy !== 8) begin n_err++; $display("FAIL busy_cycles: got %0d exp 8", nbusy); end
        model_clear_all();
        o1a = 3'd2; o2a = 3'd4;
        exp_q.push_back(mdl[2]); exp_q.push_back(mdl[4]);
        #1;
        exp = exp_q.pop_front(); n_cmp++;
        if (out1_a !== exp) begin n_err++; $display("FAIL dropped_r2: got %h exp %h", out1_a, exp); end
        exp = exp_q.pop_front(); n_cmp++;
        if (out2_a !== exp) begin n_err++; $display("FAIL cleared_r4: got %h exp %h", out2_a, exp); end
    endtask

    task automatic test_reset_mid_clear();
        do_write(3'd5, 8'hAB);
        do_write(3'd7, 8'hCD);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        repeat (4) @(negedge clk);
        // Counter now at 4: r0..r3 cleared, r5/r7 still hold data.
        o1a = 3'd5;
        exp_q.push_back(mdl[5]);
        #1;
        exp = exp_q.pop_front(); n_cmp++;
        if (out1_a !== exp) begin n_err++; $display("FAIL mid_clr_r5: got %h exp %h", out1_a, exp); end
        #1;
        rst_n = 1'b0;
        model_clear_all();
        o2a = 3'd7;
        exp_q.push_back(mdl[5]); exp_q.push_back(mdl[7]);
        #1;
        n_cmp++;
        if (busy_a !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy: got %b exp 0", busy_a); end
        exp = exp_q.pop_front(); n_cmp++;
        if (out1_a !== exp) begin n_err++; $display("FAIL rst_mid_r5: got %h exp %h", out1_a, exp); end
        exp = exp_q.pop_front(); n_cmp++;
        if (out2_a !== exp) begin n_err++; $display("FAIL rst_mid_r7: got %h exp %h", out2_a, exp); end
        @(negedge clk);
        rst_n = 1'b1;
        do_write(3'd6, 8'h5A);
        o1a = 3'd6;
        exp_q.push_back(mdl[6]);
        #1;
        exp = exp_q.pop_front(); n_cmp++;
        if (out1_a !== exp) begin n_err++; $display("FAIL post_rst_wr: got %h exp %h", out1_a, exp); end
        n_cmp++;
        if (busy_a !== 1'b0) begin n_err++; $display("FAIL post_rst_busy: got %b exp 0", busy_a); end
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        rst_n = 1'b0; in_d = 8'h00; in_addr = 3'd0; wr = 1'b0;
        o1a = 3'd0; o2a = 3'd0; clr = 1'b0;
        model_clear_all();
        test_reset();
        test_write_read();
        test_zero_bypass();
        test_clear();
        test_write_during_clear();
        test_reset_mid_clear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
